mole_scheduler: RTL and testbench

Game-play controller for the whack-a-mole datapath. It decides which of the 12 holes show a mole and for how long, and scores the hit vector produced by the mouse hit-detection stage. It runs the round timer and the IDLE/PLAY/OVER game state. Its outputs drive the VGA mole renderer and the score/timer display.

---
 rtl/mole_scheduler_if.sv | 26 ++
 rtl/mole_scheduler.sv | 211 +++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mole_scheduler_if.sv
// Handshake/bus bundle between the game controller and its neighbours.
//   start, click, hit_vec : inputs to the controller (right-click start pulse,
//                           left-click pulse, per-hole hit vector)
//   mole_active, score, misses, time_left, state, game_over : controller outputs
// Modport slave is used by mole_scheduler; modport master by the driver side.
interface mole_scheduler_if;
    logic        start;
    logic        click;
    logic [11:0] hit_vec;
    logic [11:0] mole_active;
    logic [15:0] score;
    logic [7:0]  misses;
    logic [7:0]  time_left;
    logic [1:0]  state;
    logic        game_over;

    modport slave (
        input  start, click, hit_vec,
        output mole_active, score, misses, time_left, state, game_over
    );

    modport master (
        output start, click, hit_vec,
        input  mole_active, score, misses, time_left, state, game_over
    );
endinterface

// File: rtl/mole_scheduler.sv
// Whack-a-mole game-play controller.
// Decides which of the 12 holes show a mole and for how long, scores clicks,
// runs the round timer and the IDLE/PLAY/OVER game state.
// Ports:
//   clk   : system clock, posedge
//   rst_n : asynchronous active-low reset
//   bus   : mole_scheduler_if.slave (start/click/hit_vec in; mole_active,
//           score, misses, time_left, state, game_over out, all registered)
module mole_scheduler #(
    parameter int unsigned TICK_DIV       = 25_000_000,
    parameter int unsigned GAME_TICKS     = 240,
    parameter int unsigned SPAWN_TICKS    = 4,
    parameter int unsigned LIFETIME_TICKS = 6,
    parameter int unsigned MAX_ACTIVE     = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    mole_scheduler_if.slave  bus
);
    localparam int unsigned DIV_W = $clog2(TICK_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_OVER = 2'd2
    } state_t;

    function automatic logic [3:0] popcount12(input logic [11:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 12; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [3:0] b);
        logic [16:0] s;
        s = {1'b0, a} + {13'd0, b};
        return s[16] ? 16'hFFFF : s[15:0];
    endfunction

    function automatic logic [7:0] sat_add8(input logic [7:0] a, input logic [3:0] b);
        logic [8:0] s;
        s = {1'b0, a} + {5'd0, b};
        return s[8] ? 8'hFF : s[7:0];
    endfunction

    state_t           state_r, state_nxt;
    logic [DIV_W-1:0] div_r, div_nxt;
    logic [3:0]       spawn_cnt_r, spawn_cnt_nxt;
    logic [3:0]       life_r [12];
    logic [3:0]       life_nxt [12];
    logic [11:0]      active_r, active_nxt;
    logic [15:0]      score_r, score_nxt;
    logic [7:0]       misses_r, misses_nxt;
    logic [7:0]       time_left_r, time_left_nxt;
    logic             game_over_r, game_over_nxt;
    logic [15:0]      lfsr_r;

    logic             tick_s;
    logic [11:0]      hit_s;
    logic [11:0]      expire_s;
    logic [3:0]       cand_s;
    logic [3:0]       spawn_idx_s;
    logic             spawn_free_s;

    assign tick_s = (div_r == DIV_LAST);

    // Spawn target: first hole free before this cycle, scanning up from the LFSR candidate with wrap.
    always_comb begin : spawn_scan
        logic [4:0] idx_v;
        idx_v        = 5'd0;
        cand_s       = (lfsr_r[3:0] >= 4'd12) ? (lfsr_r[3:0] - 4'd12) : lfsr_r[3:0];
        spawn_idx_s  = 4'd0;
        spawn_free_s = 1'b0;
        for (int j = 0; j < 12; j++) begin
            idx_v = {1'b0, cand_s} + 5'(j);
            if (idx_v >= 5'd12) begin
                idx_v = idx_v - 5'd12;
            end else begin
                idx_v = idx_v;
            end
            if (!spawn_free_s && !active_r[idx_v[3:0]]) begin
                spawn_free_s = 1'b1;
                spawn_idx_s  = idx_v[3:0];
            end else begin
                spawn_free_s = spawn_free_s;
            end
        end
    end

    // Game state, timer, divider, hits, expiries and spawns for the next cycle.
    always_comb begin
        state_nxt     = state_r;
        div_nxt       = div_r;
        spawn_cnt_nxt = spawn_cnt_r;
        life_nxt      = life_r;
        active_nxt    = active_r;
        score_nxt     = score_r;
        misses_nxt    = misses_r;
        time_left_nxt = time_left_r;
        hit_s         = 12'h000;
        expire_s      = 12'h000;
        unique case (state_r)
            ST_IDLE, ST_OVER: begin
                if (bus.start) begin
                    state_nxt     = ST_PLAY;
                    div_nxt       = '0;
                    spawn_cnt_nxt = 4'd0;
                    for (int i = 0; i < 12; i++) begin
                        life_nxt[i] = 4'd0;
                    end
                    active_nxt    = 12'h000;
                    score_nxt     = 16'd0;
                    misses_nxt    = 8'd0;
                    time_left_nxt = 8'(GAME_TICKS);
                end else begin
                    state_nxt = state_r;
                end
            end
            ST_PLAY: begin
                hit_s      = bus.click ? (bus.hit_vec & active_r) : 12'h000;
                score_nxt  = sat_add16(score_r, popcount12(hit_s));
                active_nxt = active_r & ~hit_s;
                if (tick_s) begin
                    div_nxt = '0;
                    // A hit on a hole wins over its expiry: hit holes skip the countdown.
                    for (int i = 0; i < 12; i++) begin
                        if (active_r[i] && !hit_s[i]) begin
                            life_nxt[i] = life_r[i] - 4'd1;
                            expire_s[i] = (life_r[i] == 4'd1);
                        end else begin
                            expire_s[i] = 1'b0;
                        end
                    end
                    active_nxt = active_nxt & ~expire_s;
                    misses_nxt = sat_add8(misses_r, popcount12(expire_s));
                    if (time_left_r == 8'd1) begin
                        state_nxt     = ST_OVER;
                        time_left_nxt = 8'd0;
                        active_nxt    = 12'h000;
                    end else begin
                        time_left_nxt = time_left_r - 8'd1;
                        if ((spawn_cnt_r + 4'd1) == 4'(SPAWN_TICKS)) begin
                            spawn_cnt_nxt = 4'd0;
                            if ((popcount12(active_r) < 4'(MAX_ACTIVE)) && spawn_free_s) begin
                                active_nxt[spawn_idx_s] = 1'b1;
                                life_nxt[spawn_idx_s]   = 4'(LIFETIME_TICKS);
                            end else begin
                                spawn_cnt_nxt = 4'd0;
                            end
                        end else begin
                            spawn_cnt_nxt = spawn_cnt_r + 4'd1;
                        end
                    end
                end else begin
                    div_nxt = div_r + DIV_W'(1);
                end
            end
            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
        game_over_nxt = (state_nxt == ST_OVER);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= ST_IDLE;
            div_r       <= '0;
            spawn_cnt_r <= 4'd0;
            for (int i = 0; i < 12; i++) begin
                life_r[i] <= 4'd0;
            end
            active_r    <= 12'h000;
            score_r     <= 16'd0;
            misses_r    <= 8'd0;
            time_left_r <= 8'd0;
            game_over_r <= 1'b0;
        end else begin
            state_r     <= state_nxt;
            div_r       <= div_nxt;
            spawn_cnt_r <= spawn_cnt_nxt;
            life_r      <= life_nxt;
            active_r    <= active_nxt;
            score_r     <= score_nxt;
            misses_r    <= misses_nxt;
            time_left_r <= time_left_nxt;
            game_over_r <= game_over_nxt;
        end
    end

    // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11), steps in every state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_r <= 16'hACE1;
        end else begin
            lfsr_r <= {lfsr_r[0] ^ lfsr_r[2] ^ lfsr_r[3] ^ lfsr_r[5], lfsr_r[15:1]};
        end
    end

    assign bus.mole_active = active_r;
    assign bus.score       = score_r;
    assign bus.misses      = misses_r;
    assign bus.time_left   = time_left_r;
    assign bus.state       = state_r;
    assign bus.game_over   = game_over_r;
endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: three instances with different
// parameter sets run side by side against a behavioural game model.
module tb_mole_scheduler;
    logic clk = 1'b0;
    logic rst_n;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mole_scheduler_if if_a ();
    mole_scheduler_if if_b ();
    mole_scheduler_if if_c ();

    mole_scheduler #(.TICK_DIV(2), .GAME_TICKS(200), .SPAWN_TICKS(1), .LIFETIME_TICKS(15), .MAX_ACTIVE(3))
        dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    mole_scheduler #(.TICK_DIV(2), .GAME_TICKS(255), .SPAWN_TICKS(1), .LIFETIME_TICKS(2), .MAX_ACTIVE(12))
        dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));
    mole_scheduler #(.TICK_DIV(3), .GAME_TICKS(5), .SPAWN_TICKS(2), .LIFETIME_TICKS(3), .MAX_ACTIVE(2))
        dut_c (.clk(clk), .rst_n(rst_n), .bus(if_c));

    // model parameters per instance (0=a, 1=b, 2=c)
    int p_div[3], p_game[3], p_spawn[3], p_life[3], p_max[3];
    // model state
    int        m_st[3], m_score[3], m_miss[3], m_tl[3], m_div[3], m_spc[3];
    int        m_life[3][12];
    bit [11:0] m_act[3];
    bit [15:0] m_lfsr[3];

    task automatic mdl_reset();
        for (int k = 0; k < 3; k++) begin
            m_st[k] = 0; m_score[k] = 0; m_miss[k] = 0; m_tl[k] = 0;
            m_div[k] = 0; m_spc[k] = 0; m_act[k] = '0; m_lfsr[k] = 16'hACE1;
            for (int i = 0; i < 12; i++) m_life[k][i] = 0;
        end
    endtask

    task automatic mdl_step(input int k, input bit s, input bit ck, input bit [11:0] hv);
        bit [11:0] old_a, h, nact;
        bit        tick;
        int        n, c, hole, fb, l;
        old_a = m_act[k];
        if (m_st[k] != 1) begin
            if (s) begin
                m_st[k] = 1; m_score[k] = 0; m_miss[k] = 0; m_act[k] = '0;
                m_div[k] = 0; m_spc[k] = 0; m_tl[k] = p_game[k];
                for (int i = 0; i < 12; i++) m_life[k][i] = 0;
            end
        end else begin
            tick = (m_div[k] == p_div[k] - 1);
            m_div[k] = tick ? 0 : m_div[k] + 1;
            h = ck ? (hv & old_a) : 12'h000;
            nact = old_a & ~h;
            m_score[k] = m_score[k] + $countones(h);
            if (m_score[k] > 65535) m_score[k] = 65535;
            if (tick) begin
                n = 0;
                for (int i = 0; i < 12; i++) begin
                    if (old_a[i] && !h[i]) begin
                        m_life[k][i] = m_life[k][i] - 1;
                        if (m_life[k][i] == 0) begin
                            nact[i] = 1'b0;
                            n++;
                        end
                    end
                end
                m_miss[k] = (m_miss[k] + n > 255) ? 255 : m_miss[k] + n;
                if (m_tl[k] == 1) begin
                    m_tl[k] = 0; m_st[k] = 2; nact = '0;
                end else begin
                    m_tl[k] = m_tl[k] - 1;
                    m_spc[k] = m_spc[k] + 1;
                    if (m_spc[k] == p_spawn[k]) begin
                        m_spc[k] = 0;
                        if ($countones(old_a) < p_max[k]) begin
                            c = int'(m_lfsr[k]) % 16;
                            if (c >= 12) c = c - 12;
                            for (int j = 0; j < 12; j++) begin
                                hole = (c + j) % 12;
                                if (!old_a[hole]) begin
                                    nact[hole] = 1'b1;
                                    m_life[k][hole] = p_life[k];
                                    break;
                                end
                            end
                        end
                    end
                end
            end
            m_act[k] = nact;
        end
        l  = int'(m_lfsr[k]);
        fb = ((l >> 0) ^ (l >> 2) ^ (l >> 3) ^ (l >> 5)) & 1;
        m_lfsr[k] = 16'((l >> 1) | (fb << 15));
    endtask

    function automatic logic [46:0] exp_vec(input int k);
        return {m_act[k], 16'(m_score[k]), 8'(m_miss[k]), 8'(m_tl[k]), 2'(m_st[k]), m_st[k] == 2};
    endfunction

    // advance one clock: models follow the inputs present at the edge
    task automatic cyc();
        @(posedge clk);
        if (!rst_n) begin
            mdl_reset();
        end else begin
            mdl_step(0, if_a.start, if_a.click, if_a.hit_vec);
            mdl_step(1, if_b.start, if_b.click, if_b.hit_vec);
            mdl_step(2, if_c.start, if_c.click, if_c.hit_vec);
        end
        #1;
    endtask

    task automatic test_reset();
        logic [46:0] oa, ob, oc;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        mdl_reset();
        #1;
        oa = {if_a.mole_active, if_a.score, if_a.misses, if_a.time_left, if_a.state, if_a.game_over};
        ob = {if_b.mole_active, if_b.score, if_b.misses, if_b.time_left, if_b.state, if_b.game_over};
        oc = {if_c.mole_active, if_c.score, if_c.misses, if_c.time_left, if_c.state, if_c.game_over};
        total++; if (oa !== exp_vec(0)) begin bad++; $display("FAIL reset_a got=%h exp=%h", oa, exp_vec(0)); end
        total++; if (ob !== exp_vec(1)) begin bad++; $display("FAIL reset_b got=%h exp=%h", ob, exp_vec(1)); end
        total++; if (oc !== exp_vec(2)) begin bad++; $display("FAIL reset_c got=%h exp=%h", oc, exp_vec(2)); end
        cyc(); cyc();
        #1 rst_n = 1'b1;
    endtask

    task automatic test_spawn();
        logic [46:0] oa;
        if_a.start = 1'b1;
        cyc();
        if_a.start = 1'b0;
        total++;
        if (if_a.state !== 2'd1 || if_a.time_left !== 8'd200) begin
            bad++; $display("FAIL spawn_start state=%0d tl=%0d exp state=1 tl=200", if_a.state, if_a.time_left);
        end
        for (int n = 0; n < 30; n++) begin
            if_a.start = (n == 12);   // start during PLAY must be ignored
            cyc();
            if_a.start = 1'b0;
            oa = {if_a.mole_active, if_a.score, if_a.misses, if_a.time_left, if_a.state, if_a.game_over};
            total++; if (oa !== exp_vec(0)) begin bad++; $display("FAIL spawn cyc=%0d got=%h exp=%h", n, oa, exp_vec(0)); end
            total++; if ($countones(if_a.mole_active) > 3) begin bad++; $display("FAIL spawn_max cyc=%0d got=%0d exp<=3", n, $countones(if_a.mole_active)); end
        end
    endtask

    task automatic test_hit();
        logic [46:0] oa;
        bit [11:0]   hv;
        int          r, pick;
        for (int n = 0; n < 60; n++) begin
            r = $urandom_range(0, 3);
            pick = -1;
            hv = 12'h000;
            if (r == 0) begin
                if (m_act[0][5]) hv = 12'h020;
                else begin
                    for (int i = 0; i < 12; i++) if (m_act[0][i] && pick < 0) pick = i;
                    if (pick >= 0) hv = 12'h001 << pick;
                end
            end else if (r == 1) begin
                for (int i = 0; i < 12; i++) if (!m_act[0][i] && pick < 0) pick = i;
                if (pick >= 0) hv = 12'h001 << pick;
            end else if (r == 2) begin
                hv = 12'($urandom);
            end
            if_a.click   = (r != 3);
            if_a.hit_vec = hv;
            cyc();
            if_a.click   = 1'b0;
            if_a.hit_vec = 12'($urandom);
            oa = {if_a.mole_active, if_a.score, if_a.misses, if_a.time_left, if_a.state, if_a.game_over};
            total++; if (oa !== exp_vec(0)) begin bad++; $display("FAIL hit cyc=%0d hv=%h got=%h exp=%h", n, hv, oa, exp_vec(0)); end
        end
    endtask

    task automatic test_score_sat();
        logic [46:0] oa;
        force dut_a.score_r = 16'hFFFF;
        #1 release dut_a.score_r;
        m_score[0] = 65535;
        for (int n = 0; n < 20; n++) begin
            if_a.click   = 1'b1;
            if_a.hit_vec = 12'hFFF;
            cyc();
            if_a.click = 1'b0;
            oa = {if_a.mole_active, if_a.score, if_a.misses, if_a.time_left, if_a.state, if_a.game_over};
            total++; if (oa !== exp_vec(0)) begin bad++; $display("FAIL score_sat cyc=%0d got=%h exp=%h", n, oa, exp_vec(0)); end
        end
        total++; if (if_a.score !== 16'hFFFF) begin bad++; $display("FAIL score_sat_final got=%h exp=ffff", if_a.score); end
    endtask

    task automatic test_reset_mid();
        logic [46:0] oa, ob;
        #2 rst_n = 1'b0;
        mdl_reset();
        #1;
        oa = {if_a.mole_active, if_a.score, if_a.misses, if_a.time_left, if_a.state, if_a.game_over};
        ob = {if_b.mole_active, if_b.score, if_b.misses, if_b.time_left, if_b.state, if_b.game_over};
        total++; if (oa !== exp_vec(0)) begin bad++; $display("FAIL reset_mid_a got=%h exp=%h", oa, exp_vec(0)); end
        total++; if (ob !== exp_vec(1)) begin bad++; $display("FAIL reset_mid_b got=%h exp=%h", ob, exp_vec(1)); end
        #2 rst_n = 1'b1;
        if_a.start = 1'b1;
        cyc();
        if_a.start = 1'b0;
        total++;
        if (if_a.state !== 2'd1 || if_a.time_left !== 8'd200 || if_a.score !== 16'd0) begin
            bad++; $display("FAIL reset_mid_start state=%0d tl=%0d score=%0d exp 1/200/0", if_a.state, if_a.time_left, if_a.score);
        end
    endtask

    task automatic test_expiry();
        logic [46:0] ob;
        int          pre_score, hole;
        bit          found;
        if_b.start = 1'b1;
        cyc();
        if_b.start = 1'b0;
        for (int n = 0; n < 40; n++) begin
            cyc();
            ob = {if_b.mole_active, if_b.score, if_b.misses, if_b.time_left, if_b.state, if_b.game_over};
            total++; if (ob !== exp_vec(1)) begin bad++; $display("FAIL expiry cyc=%0d got=%h exp=%h", n, ob, exp_vec(1)); end
        end
        found = 1'b0;
        for (int n = 0; n < 40 && !found; n++) begin
            hole = -1;
            if (m_div[1] == p_div[1] - 1)
                for (int i = 0; i < 12; i++) if (m_act[1][i] && m_life[1][i] == 1 && hole < 0) hole = i;
            pre_score = m_score[1];
            if (hole >= 0) begin
                found = 1'b1;
                if_b.click   = 1'b1;
                if_b.hit_vec = 12'h001 << hole;
            end
            cyc();
            if_b.click = 1'b0;
            ob = {if_b.mole_active, if_b.score, if_b.misses, if_b.time_left, if_b.state, if_b.game_over};
            total++; if (ob !== exp_vec(1)) begin bad++; $display("FAIL hit_expire cyc=%0d got=%h exp=%h", n, ob, exp_vec(1)); end
            if (found) begin
                total++;
                if (if_b.score !== 16'(pre_score + 1)) begin bad++; $display("FAIL hit_expire_score got=%0d exp=%0d", if_b.score, pre_score + 1); end
            end
        end
        if (!found) begin
            total++; bad++;
            $display("FAIL hit_expire_timeout got=none exp=expiring hole within 40 cycles");
        end
    endtask

    task automatic test_misses_sat();
        logic [46:0] ob;
        force dut_b.misses_r = 8'd250;
        #1 release dut_b.misses_r;
        m_miss[1] = 250;
        for (int n = 0; n < 40; n++) begin
            cyc();
            ob = {if_b.mole_active, if_b.score, if_b.misses, if_b.time_left, if_b.state, if_b.game_over};
            total++; if (ob !== exp_vec(1)) begin bad++; $display("FAIL misses_sat cyc=%0d got=%h exp=%h", n, ob, exp_vec(1)); end
        end
        total++; if (if_b.misses !== 8'd255) begin bad++; $display("FAIL misses_sat_final got=%0d exp=255", if_b.misses); end
    endtask

    task automatic test_game_over();
        logic [46:0] oc;
        if_c.start = 1'b1;
        cyc();
        if_c.start = 1'b0;
        for (int n = 0; n < 25; n++) begin
            if_c.click   = 1'($urandom_range(0, 1));
            if_c.hit_vec = 12'($urandom);
            cyc();
            if_c.click = 1'b0;
            oc = {if_c.mole_active, if_c.score, if_c.misses, if_c.time_left, if_c.state, if_c.game_over};
            total++; if (oc !== exp_vec(2)) begin bad++; $display("FAIL game_over cyc=%0d got=%h exp=%h", n, oc, exp_vec(2)); end
        end
        total++;
        if (if_c.game_over !== 1'b1 || if_c.state !== 2'd2 || if_c.mole_active !== 12'h000 || if_c.time_left !== 8'd0) begin
            bad++; $display("FAIL over_state go=%0d st=%0d ma=%h tl=%0d exp 1/2/000/0", if_c.game_over, if_c.state, if_c.mole_active, if_c.time_left);
        end
        if_c.start = 1'b1;
        cyc();
        if_c.start = 1'b0;
        total++;
        if (if_c.state !== 2'd1 || if_c.score !== 16'd0 || if_c.misses !== 8'd0 || if_c.time_left !== 8'd5) begin
            bad++; $display("FAIL restart st=%0d score=%0d misses=%0d tl=%0d exp 1/0/0/5", if_c.state, if_c.score, if_c.misses, if_c.time_left);
        end
    endtask

    initial begin
        p_div   = '{2, 2, 3};
        p_game  = '{200, 255, 5};
        p_spawn = '{1, 1, 2};
        p_life  = '{15, 2, 3};
        p_max   = '{3, 12, 2};
        if_a.start = 1'b0; if_a.click = 1'b0; if_a.hit_vec = 12'h000;
        if_b.start = 1'b0; if_b.click = 1'b0; if_b.hit_vec = 12'h000;
        if_c.start = 1'b0; if_c.click = 1'b0; if_c.hit_vec = 12'h000;
        mdl_reset();
        test_reset();
        test_spawn();
        test_hit();
        test_score_sat();
        test_reset_mid();
        test_expiry();
        test_misses_sat();
        test_game_over();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
